// File: rtl/wb_vector_slave.sv
// ============================================================================
// Module  : wb_vector_slave
// Brief   : Wishbone classic write slave that gathers 3- or 4-lane vectors and
//           hands them to a writer through a double-buffered valid/ready port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_vector_slave #(
    parameter int WB_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CYC_I,
    input  logic                  STB_I,
    input  logic [WB_WIDTH-1:0]   ADR_I,
    input  logic [WB_WIDTH-1:0]   DAT_I,
    output logic                  ACK_O,
    input  logic                  iLongFlow,
    output logic                  oVecValid,
    input  logic                  iVecReady,
    output logic [WB_WIDTH-1:0]   oVecAddr,
    output logic [4*WB_WIDTH-1:0] oVecData,
    output logic [3:0]            oLaneMask,
    output logic                  oAbort,
    output logic                  oBusy
);

    logic [1:0]            r_lane;
    logic [WB_WIDTH-1:0]   r_stage_addr;
    logic                  r_stage_long;
    logic [4*WB_WIDTH-1:0] r_stage;
    logic                  r_ack;
    logic                  r_valid;
    logic [WB_WIDTH-1:0]   r_addr;
    logic [4*WB_WIDTH-1:0] r_data;
    logic [3:0]            r_mask;
    logic                  r_abort;

    logic                  w_req;
    logic                  w_last;
    logic                  w_lane_ok;
    logic                  w_accept;
    logic [4*WB_WIDTH-1:0] w_merged;

    // Lane 0 is never the last lane, so the staged mode is always the one that applies here.
    assign w_last    = (r_lane == 2'd3) || ((r_lane == 2'd2) && !r_stage_long);
    assign w_req     = CYC_I & STB_I & ~r_ack;
    assign w_lane_ok = ~w_last | ~r_valid | iVecReady;
    assign w_accept  = w_req & w_lane_ok;

    // Completed vector = staged lanes with the current beat merged in.
    always_comb begin
        w_merged = r_stage;
        for (int k = 0; k < 4; k++) begin
            if (r_lane == 2'(k)) begin
                w_merged[k*WB_WIDTH +: WB_WIDTH] = DAT_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane       <= 2'd0;
            r_stage_addr <= '0;
            r_stage_long <= 1'b0;
            r_stage      <= '0;
            r_ack        <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_ack   <= w_accept;
            r_abort <= 1'b0;
            if (!CYC_I) begin
                r_lane  <= 2'd0;
                r_abort <= (r_lane != 2'd0);
            end else if (w_accept) begin
                if (r_lane == 2'd0) begin
                    r_stage_addr                 <= ADR_I;
                    r_stage_long                 <= iLongFlow;
                    r_stage                      <= '0;
                    r_stage[WB_WIDTH-1:0]        <= DAT_I;
                end else begin
                    r_stage[r_lane*WB_WIDTH +: WB_WIDTH] <= DAT_I;
                end
                r_lane <= w_last ? 2'd0 : r_lane + 2'd1;
            end
        end
    end

    // Output slot: a new vector loading on the same edge as a handshake keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= 4'h0;
        end else if (w_accept && w_last) begin
            r_valid <= 1'b1;
            r_addr  <= r_stage_addr;
            r_data  <= w_merged;
            r_mask  <= r_stage_long ? 4'hF : 4'h7;
        end else if (r_valid && iVecReady) begin
            r_valid <= 1'b0;
        end
    end

    assign ACK_O     = r_ack;
    assign oVecValid = r_valid;
    assign oVecAddr  = r_addr;
    assign oVecData  = r_data;
    assign oLaneMask = r_mask;
    assign oAbort    = r_abort;
    assign oBusy     = (r_lane != 2'd0) | r_valid;

endmodule

`default_nettype wire

// File: tb/tb_wb_vector_slave.sv
// ============================================================================
// Module  : tb_wb_vector_slave
// Brief   : Directed self-checking bench for wb_vector_slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_vector_slave;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           CYC_I, STB_I, iLongFlow, iVecReady;
    logic [W-1:0]   ADR_I, DAT_I;
    logic           ACK_O, oVecValid, oAbort, oBusy;
    logic [W-1:0]   oVecAddr;
    logic [4*W-1:0] oVecData;
    logic [3:0]     oLaneMask;

    int checks = 0;
    int errors = 0;

    wb_vector_slave #(.WB_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .CYC_I(CYC_I), .STB_I(STB_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
        .ACK_O(ACK_O), .iLongFlow(iLongFlow),
        .oVecValid(oVecValid), .iVecReady(iVecReady),
        .oVecAddr(oVecAddr), .oVecData(oVecData), .oLaneMask(oLaneMask),
        .oAbort(oAbort), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    // Drive one beat and return the number of edges until ACK_O (21 = never acked).
    task automatic do_beat(input logic [W-1:0] a, input logic [W-1:0] d,
                           input logic lng, output int cyc);
        if (ACK_O) begin
            @(posedge clk); #1;
        end
        CYC_I = 1'b1; STB_I = 1'b1; ADR_I = a; DAT_I = d; iLongFlow = lng;
        cyc = 0;
        while (cyc <= 20) begin
            @(posedge clk); #1;
            cyc++;
            if (ACK_O) break;
        end
        if (!ACK_O) cyc = 21;
        STB_I = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; CYC_I = 0; STB_I = 0; ADR_I = 0; DAT_I = 0;
        iLongFlow = 0; iVecReady = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ACK_O, oVecValid, oAbort, oBusy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {ACK_O, oVecValid, oAbort, oBusy});
        end
        checks++;
        if (oVecData !== '0 || oVecAddr !== '0 || oLaneMask !== 4'h0) begin
            errors++; $display("FAIL reset_regs data=%h addr=%h mask=%h exp all 0", oVecData, oVecAddr, oLaneMask);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_short_flow();
        int c1, c2, c3;
        iVecReady = 1;
        do_beat(32'h40, 32'h11, 1'b0, c1);
        do_beat(32'h40, 32'h22, 1'b0, c2);
        do_beat(32'h40, 32'h33, 1'b0, c3);
        checks++;
        if (c1 != 1 || c2 != 1 || c3 != 1) begin
            errors++; $display("FAIL short_ack_latency got=%0d,%0d,%0d exp=1,1,1", c1, c2, c3);
        end
        checks++;
        if (oVecValid !== 1'b1 || oVecData !== {32'h0, 32'h33, 32'h22, 32'h11}) begin
            errors++; $display("FAIL short_vector valid=%b data=%h exp valid=1 data=0..33_22_11", oVecValid, oVecData);
        end
        checks++;
        if (oLaneMask !== 4'h7 || oVecAddr !== 32'h40) begin
            errors++; $display("FAIL short_meta mask=%h addr=%h exp 7/40", oLaneMask, oVecAddr);
        end
        @(posedge clk); #1;
        checks++;
        if (ACK_O !== 1'b0 || oVecValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL short_after ack=%b valid=%b busy=%b exp 0/0/0", ACK_O, oVecValid, oBusy);
        end
    endtask

    task automatic test_long_flow();
        int c;
        iVecReady = 1;
        do_beat(32'h80, 32'hA, 1'b1, c);
        do_beat(32'h80, 32'hB, 1'b1, c);
        do_beat(32'h80, 32'hC, 1'b1, c);
        checks++;
        if (oVecValid !== 1'b0 || oBusy !== 1'b1) begin
            errors++; $display("FAIL long_early valid=%b busy=%b exp 0/1", oVecValid, oBusy);
        end
        do_beat(32'h80, 32'hD, 1'b1, c);
        checks++;
        if (oVecValid !== 1'b1 || oLaneMask !== 4'hF || oVecAddr !== 32'h80 ||
            oVecData !== {32'hD, 32'hC, 32'hB, 32'hA}) begin
            errors++; $display("FAIL long_vector valid=%b mask=%h addr=%h data=%h exp 1/F/80/D_C_B_A",
                               oVecValid, oLaneMask, oVecAddr, oVecData);
        end
        @(posedge clk); #1;
        checks++;
        if (oVecValid !== 1'b0) begin
            errors++; $display("FAIL long_pulse valid=%b exp 0", oVecValid);
        end
    endtask

    task automatic test_back_to_back_stall();
        int c;
        logic [4*W-1:0] v1, v2;
        v1 = {32'h0, 32'h3, 32'h2, 32'h1};
        v2 = {32'h0, 32'h6, 32'h5, 32'h4};
        iVecReady = 0;
        do_beat(32'h100, 32'h1, 1'b0, c);
        do_beat(32'h100, 32'h2, 1'b0, c);
        do_beat(32'h100, 32'h3, 1'b0, c);
        do_beat(32'h200, 32'h4, 1'b0, c);
        do_beat(32'h200, 32'h5, 1'b0, c);
        checks++;
        if (c != 1 || oVecValid !== 1'b1 || oVecData !== v1) begin
            errors++; $display("FAIL b2b_lane1 cyc=%0d valid=%b data=%h exp 1/1/v1", c, oVecValid, oVecData);
        end
        @(posedge clk); #1;
        CYC_I = 1; STB_I = 1; DAT_I = 32'h6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ACK_O !== 1'b0 || oVecValid !== 1'b1 || oVecData !== v1 || oVecAddr !== 32'h100) begin
                errors++; $display("FAIL b2b_stall%0d ack=%b valid=%b data=%h addr=%h exp 0/1/v1/100",
                                   i, ACK_O, oVecValid, oVecData, oVecAddr);
            end
        end
        iVecReady = 1;
        @(posedge clk); #1;
        STB_I = 0;
        checks++;
        if (ACK_O !== 1'b1 || oVecValid !== 1'b1 || oVecData !== v2 || oVecAddr !== 32'h200) begin
            errors++; $display("FAIL b2b_replace ack=%b valid=%b data=%h addr=%h exp 1/1/v2/200",
                               ACK_O, oVecValid, oVecData, oVecAddr);
        end
        @(posedge clk); #1;
        checks++;
        if (oVecValid !== 1'b0 || ACK_O !== 1'b0) begin
            errors++; $display("FAIL b2b_drain valid=%b ack=%b exp 0/0", oVecValid, ACK_O);
        end
    endtask

    task automatic test_abort();
        int c;
        iVecReady = 1;
        do_beat(32'h300, 32'h1, 1'b1, c);
        do_beat(32'h300, 32'h2, 1'b1, c);
        CYC_I = 0;
        @(posedge clk); #1;
        checks++;
        if (oAbort !== 1'b1 || oVecValid !== 1'b0) begin
            errors++; $display("FAIL abort_pulse abort=%b valid=%b exp 1/0", oAbort, oVecValid);
        end
        @(posedge clk); #1;
        checks++;
        if (oAbort !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL abort_end abort=%b busy=%b exp 0/0", oAbort, oBusy);
        end
        do_beat(32'h400, 32'h21, 1'b1, c);
        do_beat(32'h400, 32'h22, 1'b1, c);
        do_beat(32'h400, 32'h23, 1'b1, c);
        do_beat(32'h400, 32'h24, 1'b1, c);
        checks++;
        if (oVecValid !== 1'b1 || oVecAddr !== 32'h400 || oLaneMask !== 4'hF ||
            oVecData !== {32'h24, 32'h23, 32'h22, 32'h21}) begin
            errors++; $display("FAIL abort_recover valid=%b addr=%h mask=%h data=%h exp 1/400/F/24_23_22_21",
                               oVecValid, oVecAddr, oLaneMask, oVecData);
        end
        CYC_I = 0;
        @(posedge clk); #1;
        checks++;
        if (oAbort !== 1'b0) begin
            errors++; $display("FAIL abort_spurious abort=%b exp 0", oAbort);
        end
    endtask

    task automatic test_async_reset();
        int c;
        iVecReady = 0;
        do_beat(32'h500, 32'h51, 1'b0, c);
        do_beat(32'h500, 32'h52, 1'b0, c);
        do_beat(32'h500, 32'h53, 1'b0, c);
        do_beat(32'h600, 32'h61, 1'b0, c);
        do_beat(32'h600, 32'h62, 1'b0, c);
        @(posedge clk); #1;
        STB_I = 1; DAT_I = 32'h63;
        @(posedge clk); #1;
        checks++;
        if (ACK_O !== 1'b0 || oVecValid !== 1'b1) begin
            errors++; $display("FAIL rst_prestall ack=%b valid=%b exp 0/1", ACK_O, oVecValid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ACK_O !== 1'b0 || oVecValid !== 1'b0 || oVecData !== '0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL rst_async ack=%b valid=%b data=%h busy=%b exp all 0",
                               ACK_O, oVecValid, oVecData, oBusy);
        end
        STB_I = 0; CYC_I = 0; iVecReady = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_beat(32'h700, 32'h71, 1'b0, c);
        do_beat(32'h700, 32'h72, 1'b0, c);
        do_beat(32'h700, 32'h73, 1'b0, c);
        checks++;
        if (oVecValid !== 1'b1 || oVecAddr !== 32'h700 || oLaneMask !== 4'h7 ||
            oVecData !== {32'h0, 32'h73, 32'h72, 32'h71}) begin
            errors++; $display("FAIL rst_recover valid=%b addr=%h mask=%h data=%h exp 1/700/7/0_73_72_71",
                               oVecValid, oVecAddr, oLaneMask, oVecData);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mode_change();
        int c;
        iVecReady = 1;
        do_beat(32'h800, 32'h81, 1'b0, c);
        do_beat(32'h800, 32'h82, 1'b1, c);
        do_beat(32'h800, 32'h83, 1'b1, c);
        checks++;
        if (oVecValid !== 1'b1 || oLaneMask !== 4'h7 || oVecAddr !== 32'h800 ||
            oVecData !== {32'h0, 32'h83, 32'h82, 32'h81}) begin
            errors++; $display("FAIL mode_ignored valid=%b mask=%h addr=%h data=%h exp 1/7/800/0_83_82_81",
                               oVecValid, oLaneMask, oVecAddr, oVecData);
        end
        @(posedge clk); #1;
        checks++;
        if (oBusy !== 1'b0) begin
            errors++; $display("FAIL mode_lane_wrap busy=%b exp 0", oBusy);
        end
    endtask

    task automatic test_stb_no_cyc();
        CYC_I = 0; STB_I = 1; DAT_I = 32'hEE;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ACK_O !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL stb_no_cyc ack=%b busy=%b exp 0/0", ACK_O, oBusy);
        end
        STB_I = 0;
    endtask

    initial begin
        test_reset();
        test_short_flow();
        test_long_flow();
        test_back_to_back_stall();
        test_abort();
        test_async_reset();
        test_mode_change();
        test_stb_no_cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
